// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and turns set-2 make/break
// sequences into the code of the key currently held.
//
// Handshake: code_valid is a one-cycle qualifier for code_byte. There is no
// ready; a consumer that misses the pulse can still read code_byte, which is
// held until the next good byte. frame_err is a one-cycle event with no data.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 130000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] result,
    output logic       code_valid,
    output logic [7:0] code_byte,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Input conditioning flops
    logic                  clk_meta_q, clk_meta_d;
    logic                  clk_sync_q, clk_sync_d;
    logic                  data_meta_q, data_meta_d;
    logic                  data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] clk_hist_q, clk_hist_d;
    logic                  filt_q, filt_d;
    logic                  fall_evt;

    // Framing and key-tracking flops
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_q, brk_d;
    logic [7:0]    result_q, result_d;
    logic [7:0]    code_byte_q, code_byte_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout;
    logic          frame_good;

    // Synchronize both pins, debounce ps2_clk and detect its filtered fall.
    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
        clk_hist_d  = {clk_hist_q[FILTER_LEN-2:0], clk_sync_q};
        filt_d      = filt_q;
        if (&clk_hist_q) begin
            filt_d = 1'b1;
        end else if (~|clk_hist_q) begin
            filt_d = 1'b0;
        end
        // Only true in the single cycle the filtered level drops.
        fall_evt = filt_q && (~|clk_hist_q);
    end

    // Pin conditioning registers; idle PS/2 lines are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_hist_q  <= '1;
            filt_q      <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            clk_hist_q  <= clk_hist_d;
            filt_q      <= filt_d;
        end
    end

    // Frame FSM, inactivity timeout and make/break interpretation.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        brk_d        = brk_q;
        result_d     = result_q;
        code_byte_d  = code_byte_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_good   = data_sync_q && (^{shift_q, parity_q});

        // A fall event on the terminal-count cycle takes priority: the bit
        // is accepted and the counter restarts.
        timeout = (state_q != S_IDLE) && !fall_evt && (to_cnt_q == TO_TERM);

        if (state_q == S_IDLE || fall_evt || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                // A fall with data high is a spurious edge, silently ignored.
                if (fall_evt && !data_sync_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall_evt) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall_evt) begin
                    parity_d = data_sync_q;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_evt) begin
                    state_d = S_IDLE;
                    if (frame_good) begin
                        code_valid_d = 1'b1;
                        code_byte_d  = shift_q;
                        case (shift_q)
                            8'hE0: ;  // extended prefix: break flag kept
                            8'hF0: brk_d = 1'b1;
                            8'hAA, 8'hFA, 8'hEE,
                            8'hFE, 8'h00, 8'hFF: brk_d = 1'b0;
                            default: begin
                                if (brk_q) begin
                                    // Releasing a key other than the held one
                                    // leaves the held key in place.
                                    if (shift_q == result_q) begin
                                        result_d = 8'h00;
                                    end
                                    brk_d = 1'b0;
                                end else begin
                                    result_d = shift_q;
                                end
                            end
                        endcase
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d     = S_IDLE;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b1;
        end
    end

    // Framing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            brk_q        <= 1'b0;
            result_q     <= 8'h00;
            code_byte_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            brk_q        <= brk_d;
            result_q     <= result_d;
            code_byte_q  <= code_byte_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign result     = result_q;
    assign code_valid = code_valid_q;
    assign code_byte  = code_byte_q;
    assign frame_err  = frame_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives bit-level PS/2 frames on the pins and
// checks decoded bytes, held-key result and error pulses.
module tb_ps2_keyboard_rx;

    localparam int HALF = 20;  // clk cycles per PS/2 clock phase

    typedef struct {
        logic [7:0] b;
        bit         par_flip;
        bit         stop;
        bit         glitch;
        logic [7:0] exp_result;
    } vec_t;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] result;
    logic       code_valid;
    logic [7:0] code_byte;
    logic       frame_err;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .result    (result),
        .code_valid(code_valid),
        .code_byte (code_byte),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // scoreboard state
    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         exp_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] last_good = 8'h00;
    vec_t       vecs[$];

    // collect every DUT output event
    always @(posedge clk) begin
        #1;
        if (code_valid) got_q.push_back(code_byte);
        if (frame_err) err_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // pop every observed byte against the expected queue
    task automatic drain(input string name);
        logic [7:0] g;
        logic [7:0] e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected code_valid byte %h", name, g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s code_byte got %h expected %h", name, g, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing %0d code_valid pulses", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // driver: one PS/2 bit, data set while the line clock is high
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_clk(HALF / 2);
            ps2_clk = 1'b0;
            wait_clk(2);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2 - 2);
        end else begin
            wait_clk(HALF);
        end
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_b,
                              input bit glitch, input int nbits);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = (~^b) ^ par_flip;
        fr[10]  = stop_b;
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i], glitch && (i == 3 || i == 6));
        end
        ps2_data = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic add_vec(input logic [7:0] b, input bit pf, input bit st, input bit gl,
                           input logic [7:0] er);
        vec_t v;
        v.b = b; v.par_flip = pf; v.stop = st; v.glitch = gl; v.exp_result = er;
        vecs.push_back(v);
    endtask

    initial begin
        // single make
        add_vec(8'h23, 0, 1, 0, 8'h23);
        // make / break of the held key
        add_vec(8'h1C, 0, 1, 0, 8'h1C);
        add_vec(8'hF0, 0, 1, 0, 8'h1C);
        add_vec(8'h1C, 0, 1, 0, 8'h00);
        // release of a non-current key, extended make
        add_vec(8'h1C, 0, 1, 0, 8'h1C);
        add_vec(8'h23, 0, 1, 0, 8'h23);
        add_vec(8'hF0, 0, 1, 0, 8'h23);
        add_vec(8'h1C, 0, 1, 0, 8'h23);
        add_vec(8'hE0, 0, 1, 0, 8'h23);
        add_vec(8'h75, 0, 1, 0, 8'h75);
        // keyboard response clears a pending break
        add_vec(8'hF0, 0, 1, 0, 8'h75);
        add_vec(8'hAA, 0, 1, 0, 8'h75);
        add_vec(8'h1C, 0, 1, 0, 8'h1C);
        // prefix between break and code keeps the break flag
        add_vec(8'hE0, 0, 1, 0, 8'h1C);
        add_vec(8'hF0, 0, 1, 0, 8'h1C);
        add_vec(8'hE0, 0, 1, 0, 8'h1C);
        add_vec(8'h1C, 0, 1, 0, 8'h00);
        // typematic repeat then release
        add_vec(8'h23, 0, 1, 0, 8'h23);
        add_vec(8'h23, 0, 1, 0, 8'h23);
        add_vec(8'hF0, 0, 1, 0, 8'h23);
        add_vec(8'h23, 0, 1, 0, 8'h00);
        // bad parity, bad stop: nothing changes
        add_vec(8'h1C, 1, 1, 0, 8'h00);
        add_vec(8'h1C, 0, 0, 0, 8'h00);
        // line-clock glitches inside a good frame
        add_vec(8'h1C, 0, 1, 1, 8'h1C);

        // reset state
        wait_clk(4);
        check8("reset_result", result, 8'h00);
        check8("reset_code_byte", code_byte, 8'h00);
        check8("reset_code_valid", {7'd0, code_valid}, 8'h00);
        check8("reset_frame_err", {7'd0, frame_err}, 8'h00);
        check8("reset_state", {6'd0, state_dbg}, 8'h00);
        rst = 1'b0;
        wait_clk(10);

        // table-driven frames
        foreach (vecs[i]) begin
            if (!vecs[i].par_flip && vecs[i].stop) begin
                exp_q.push_back(vecs[i].b);
                last_good = vecs[i].b;
            end else begin
                exp_err++;
            end
            send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop, vecs[i].glitch, 11);
            wait_clk(5);
            drain($sformatf("vec%0d", i));
            check8($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
            check8($sformatf("vec%0d_code_byte", i), code_byte, last_good);
            check_int($sformatf("vec%0d_frame_err", i), err_seen, exp_err);
        end

        // timeout: start + 4 data bits, then the line clock stays high
        send_frame(8'h55, 0, 1, 0, 5);
        wait_clk(300);
        exp_err++;
        drain("timeout");
        check_int("timeout_frame_err", err_seen, exp_err);
        check8("timeout_code_byte", code_byte, last_good);
        exp_q.push_back(8'h23);
        last_good = 8'h23;
        send_frame(8'h23, 0, 1, 0, 11);
        wait_clk(5);
        drain("after_timeout");
        check8("after_timeout_code_byte", code_byte, 8'h23);
        check8("after_timeout_result", result, 8'h23);
        check_int("after_timeout_frame_err", err_seen, exp_err);

        // reset mid-frame
        send_frame(8'h1C, 0, 1, 0, 4);
        rst = 1'b1;
        wait_clk(2);
        check8("midrst_result", result, 8'h00);
        check8("midrst_code_byte", code_byte, 8'h00);
        check8("midrst_code_valid", {7'd0, code_valid}, 8'h00);
        check8("midrst_frame_err", {7'd0, frame_err}, 8'h00);
        check8("midrst_state", {6'd0, state_dbg}, 8'h00);
        rst = 1'b0;
        last_good = 8'h00;
        wait_clk(HALF);
        exp_q.push_back(8'h1C);
        last_good = 8'h1C;
        send_frame(8'h1C, 0, 1, 0, 11);
        wait_clk(5);
        drain("after_rst");
        check8("after_rst_code_byte", code_byte, 8'h1C);
        check8("after_rst_result", result, 8'h1C);
        check_int("after_rst_frame_err", err_seen, exp_err);

        // idle glitch with data high
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        wait_clk(2);
        ps2_clk = 1'b1;
        wait_clk(HALF);
        drain("idle_glitch");
        check_int("idle_glitch_frame_err", err_seen, exp_err);

        // full spurious edge with data high while idle
        ps2_bit(1'b1, 0);
        wait_clk(HALF);
        drain("idle_edge");
        check_int("idle_edge_frame_err", err_seen, exp_err);
        check8("idle_edge_state", {6'd0, state_dbg}, 8'h00);

        // receiver still in step afterwards
        exp_q.push_back(8'h75);
        last_good = 8'h75;
        send_frame(8'h75, 0, 1, 0, 11);
        wait_clk(5);
        drain("final");
        check8("final_result", result, 8'h75);
        check8("final_code_byte", code_byte, 8'h75);
        check_int("final_frame_err", err_seen, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
